buf_loader: RTL and testbench

BUF_LOADER -- requirements
Module: buf_loader

---
 rtl/buf_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_buf_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/buf_loader.sv
// Stream loader: writes 32-bit beats into the IFM buffer, and packs 3 beats
// per entry into the four filter buffers (72-bit entries).
`ifndef W_SIZE
`define W_SIZE 8
`endif
`ifndef W_CHANNEL
`define W_CHANNEL 8
`endif
`ifndef IFM_DW
`define IFM_DW 32
`endif
`ifndef FILTER_DW
`define FILTER_DW 72
`endif
`ifndef IFM_TOTAL_BUFFER_AW
`define IFM_TOTAL_BUFFER_AW 12
`endif
`ifndef FILTER_BUFFER_AW
`define FILTER_BUFFER_AW 8
`endif

module buf_loader #(
  parameter int W_SIZE    = `W_SIZE,
  parameter int W_CHANNEL = `W_CHANNEL,
  parameter int IFM_DW    = `IFM_DW,
  parameter int FILTER_DW = `FILTER_DW,
  parameter int IFM_AW    = `IFM_TOTAL_BUFFER_AW,
  parameter int FILTER_AW = `FILTER_BUFFER_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W_SIZE-1:0]    q_width,
  input  logic [W_SIZE-1:0]    q_height,
  input  logic [W_CHANNEL-1:0] q_channel,
  input  logic                 q_load_ifm,
  output logic                 o_load_ifm_done,
  input  logic                 q_load_filter,
  output logic                 o_load_filter_done,
  input  logic [IFM_DW-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 ifm_ena,
  output logic                 ifm_wea,
  output logic [IFM_AW-1:0]    ifm_addra,
  output logic [IFM_DW-1:0]    ifm_dia,
  output logic [3:0]           fb_ena,
  output logic [3:0]           fb_wea,
  output logic [FILTER_AW-1:0] fb_addra,
  output logic [FILTER_DW-1:0] fb_dia,
  output logic                 o_busy
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_IFM     = 3'd1;
  localparam logic [2:0] S_FLT     = 3'd2;
  localparam logic [2:0] S_FIN_IFM = 3'd3;
  localparam logic [2:0] S_FIN_FLT = 3'd4;
  localparam int PW = 2 * W_SIZE + W_CHANNEL;

  logic [2:0]           state_q, state_d;
  logic                 pend_ifm_q, pend_ifm_d, pend_flt_q, pend_flt_d;
  logic [W_SIZE-1:0]    lat_w_q, lat_w_d, lat_h_q, lat_h_d;
  logic [W_CHANNEL-1:0] lat_c_q, lat_c_d;
  logic [IFM_AW:0]      cnt_q, cnt_d;
  logic [1:0]           beat_q, beat_d;
  logic [W_CHANNEL-1:0] ch_q, ch_d;
  logic [1:0]           flt_q, flt_d;
  logic [63:0]          asm_q, asm_d;
  logic                 ifm_we_q, ifm_we_d;
  logic [IFM_AW-1:0]    ifm_addr_q, ifm_addr_d;
  logic [IFM_DW-1:0]    ifm_data_q, ifm_data_d;
  logic [3:0]           fb_we_q, fb_we_d;
  logic [FILTER_AW-1:0] fb_addr_q, fb_addr_d;
  logic [FILTER_DW-1:0] fb_data_q, fb_data_d;
  logic                 done_ifm_q, done_ifm_d, done_flt_q, done_flt_d;
  logic [IFM_AW:0]      n_beats;
  logic                 ifm_go, flt_go, acc;

  // Product taken at full width, then truncated to the counter width.
  assign n_beats = (IFM_AW+1)'(PW'(lat_h_q) * PW'(lat_w_q) * PW'(lat_c_q));

  assign s_ready = ((state_q == S_IFM) && (n_beats != '0)) ||
                   ((state_q == S_FLT) && (lat_c_q != '0));
  assign acc     = s_valid & s_ready;
  assign ifm_go  = q_load_ifm | pend_ifm_q;
  assign flt_go  = q_load_filter | pend_flt_q;

  always_comb begin
    state_d    = state_q;
    pend_ifm_d = ifm_go;
    pend_flt_d = flt_go;
    lat_w_d    = lat_w_q;
    lat_h_d    = lat_h_q;
    lat_c_d    = lat_c_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    ch_d       = ch_q;
    flt_d      = flt_q;
    asm_d      = asm_q;
    ifm_we_d   = 1'b0;
    ifm_addr_d = ifm_addr_q;
    ifm_data_d = ifm_data_q;
    fb_we_d    = 4'b0000;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    done_ifm_d = 1'b0;
    done_flt_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ifm_go || flt_go) begin
          lat_w_d = q_width;
          lat_h_d = q_height;
          lat_c_d = q_channel;
          cnt_d   = '0;
          beat_d  = '0;
          ch_d    = '0;
          flt_d   = '0;
        end
        if (ifm_go) begin
          state_d    = S_IFM;
          pend_ifm_d = 1'b0;
        end else if (flt_go) begin
          state_d    = S_FLT;
          pend_flt_d = 1'b0;
        end
      end
      S_IFM: begin
        if (n_beats == '0) begin
          state_d = S_FIN_IFM;
        end else if (acc) begin
          ifm_we_d   = 1'b1;
          ifm_addr_d = cnt_q[IFM_AW-1:0];
          ifm_data_d = s_data;
          cnt_d      = cnt_q + (IFM_AW+1)'(1);
          if (cnt_q == n_beats - (IFM_AW+1)'(1)) state_d = S_FIN_IFM;
        end
      end
      S_FLT: begin
        if (lat_c_q == '0) begin
          state_d = S_FIN_FLT;
        end else if (acc) begin
          case (beat_q)
            2'd0: begin
              asm_d[31:0] = s_data[31:0];
              beat_d      = 2'd1;
            end
            2'd1: begin
              asm_d[63:32] = s_data[31:0];
              beat_d       = 2'd2;
            end
            default: begin
              // Third beat completes the entry; only its low byte is kept.
              fb_we_d   = 4'b0001 << flt_q;
              fb_addr_d = FILTER_AW'(ch_q);
              fb_data_d = FILTER_DW'({s_data[7:0], asm_q});
              beat_d    = 2'd0;
              if (ch_q == lat_c_q - W_CHANNEL'(1)) begin
                ch_d  = '0;
                flt_d = flt_q + 2'd1;
                if (flt_q == 2'd3) state_d = S_FIN_FLT;
              end else begin
                ch_d = ch_q + W_CHANNEL'(1);
              end
            end
          endcase
        end
      end
      S_FIN_IFM: begin
        state_d    = S_IDLE;
        done_ifm_d = 1'b1;
      end
      S_FIN_FLT: begin
        state_d    = S_IDLE;
        done_flt_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_ifm_q <= 1'b0;
      pend_flt_q <= 1'b0;
      lat_w_q    <= '0;
      lat_h_q    <= '0;
      lat_c_q    <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
      ch_q       <= '0;
      flt_q      <= '0;
      asm_q      <= '0;
      ifm_we_q   <= 1'b0;
      ifm_addr_q <= '0;
      ifm_data_q <= '0;
      fb_we_q    <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      done_ifm_q <= 1'b0;
      done_flt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_ifm_q <= pend_ifm_d;
      pend_flt_q <= pend_flt_d;
      lat_w_q    <= lat_w_d;
      lat_h_q    <= lat_h_d;
      lat_c_q    <= lat_c_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      ch_q       <= ch_d;
      flt_q      <= flt_d;
      asm_q      <= asm_d;
      ifm_we_q   <= ifm_we_d;
      ifm_addr_q <= ifm_addr_d;
      ifm_data_q <= ifm_data_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      done_ifm_q <= done_ifm_d;
      done_flt_q <= done_flt_d;
    end
  end

  assign ifm_ena            = ifm_we_q;
  assign ifm_wea            = ifm_we_q;
  assign ifm_addra          = ifm_addr_q;
  assign ifm_dia            = ifm_data_q;
  assign fb_ena             = fb_we_q;
  assign fb_wea             = fb_we_q;
  assign fb_addra           = fb_addr_q;
  assign fb_dia             = fb_data_q;
  assign o_load_ifm_done    = done_ifm_q;
  assign o_load_filter_done = done_flt_q;
  assign o_busy             = (state_q != S_IDLE);
endmodule

// File: tb/tb_buf_loader.sv
// Directed bench for buf_loader: table of load scenarios plus hand-written
// sequences for simultaneous requests and mid-load reset.
module tb_buf_loader;
  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   q_width, q_height, q_channel;
  logic         q_load_ifm, q_load_filter;
  logic         o_load_ifm_done, o_load_filter_done;
  logic [31:0]  s_data;
  logic         s_valid, s_ready;
  logic         ifm_ena, ifm_wea;
  logic [11:0]  ifm_addra;
  logic [31:0]  ifm_dia;
  logic [3:0]   fb_ena, fb_wea;
  logic [7:0]   fb_addra;
  logic [71:0]  fb_dia;
  logic         o_busy;

  buf_loader #(.W_SIZE(8), .W_CHANNEL(8), .IFM_DW(32), .FILTER_DW(72),
               .IFM_AW(12), .FILTER_AW(8)) dut (
    .clk(clk), .rst(rst), .q_width(q_width), .q_height(q_height),
    .q_channel(q_channel), .q_load_ifm(q_load_ifm),
    .o_load_ifm_done(o_load_ifm_done), .q_load_filter(q_load_filter),
    .o_load_filter_done(o_load_filter_done), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .ifm_ena(ifm_ena),
    .ifm_wea(ifm_wea), .ifm_addra(ifm_addra), .ifm_dia(ifm_dia),
    .fb_ena(fb_ena), .fb_wea(fb_wea), .fb_addra(fb_addra),
    .fb_dia(fb_dia), .o_busy(o_busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [11:0] addr; logic [31:0] data; logic en; int cyc; } ifm_wr_t;
  typedef struct { logic [3:0] we; logic [3:0] en; logic [7:0] addr; logic [71:0] data; int cyc; } fb_wr_t;
  typedef struct { bit is_flt; int w; int h; int c; bit gap; int n; } vec_t;

  ifm_wr_t ifm_q[$];
  fb_wr_t  fb_q[$];
  int      ifm_done_q[$], flt_done_q[$], acc_cyc[$];
  int      n_tests = 0, n_fail = 0;
  int      acc_n, last_acc, rdy_hits;

  always @(negedge clk) begin : mon
    ifm_wr_t iw;
    fb_wr_t  fw;
    if (ifm_wea) begin
      iw.addr = ifm_addra; iw.data = ifm_dia; iw.en = ifm_ena; iw.cyc = cyc;
      ifm_q.push_back(iw);
    end
    if (fb_wea != 4'b0000) begin
      fw.we = fb_wea; fw.en = fb_ena; fw.addr = fb_addra; fw.data = fb_dia; fw.cyc = cyc;
      fb_q.push_back(fw);
    end
    if (o_load_ifm_done) ifm_done_q.push_back(cyc);
    if (o_load_filter_done) flt_done_q.push_back(cyc);
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ifm_q.delete(); fb_q.delete(); ifm_done_q.delete(); flt_done_q.delete(); acc_cyc.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctrl zero"}, {s_ready, ifm_ena, ifm_wea, fb_ena, fb_wea,
          o_load_ifm_done, o_load_filter_done, o_busy}, '0);
    check({tag, " addr zero"}, {ifm_addra, fb_addra}, '0);
    check({tag, " data zero"}, {ifm_dia, fb_dia}, '0);
  endtask

  // Streams beats base+k until n accepted, then holds s_valid high for extra cycles.
  task automatic run_stream(input int n, input bit gap, input logic [31:0] base, input int extra);
    int  budget = 0;
    bit  ph = 1'b0;
    logic rdy;
    acc_n = 0; last_acc = -1; rdy_hits = 0;
    while (acc_n < n && budget < 400) begin
      s_valid = gap ? ~ph : 1'b1;
      ph = ~ph;
      s_data = base + acc_n;
      rdy = s_ready;
      step();
      if (s_valid && rdy) begin
        acc_n++; last_acc = cyc; acc_cyc.push_back(cyc);
      end
      budget++;
    end
    for (int i = 0; i < extra; i++) begin
      s_valid = 1'b1; s_data = 32'hDEADBEEF;
      if (s_ready) rdy_hits++;
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic start_load(input bit ifm, input bit flt, input int w, input int h,
                            input int c, output int e);
    q_width = 8'(w); q_height = 8'(h); q_channel = 8'(c);
    q_load_ifm = ifm; q_load_filter = flt;
    step();
    q_load_ifm = 1'b0; q_load_filter = 1'b0;
    e = cyc;
  endtask

  task automatic run_case(input string tag, input vec_t v);
    int e;
    logic [31:0] base, b0, b1, b2;
    clear_logs();
    base = v.is_flt ? 32'hA0000000 : 32'h00000100;
    start_load(!v.is_flt, v.is_flt, v.w, v.h, v.c, e);
    q_width = 8'd7; q_height = 8'd7; q_channel = 8'd7;
    run_stream(v.n, v.gap, base, 3);
    step(); step();
    check({tag, " accepted"}, acc_n, v.n);
    check({tag, " extra beats"}, rdy_hits, 0);
    if (!v.is_flt) begin
      check({tag, " wr count"}, ifm_q.size(), v.n);
      check({tag, " fb count"}, fb_q.size(), 0);
      for (int j = 0; j < ifm_q.size() && j < v.n; j++) begin
        check($sformatf("%s wr%0d addr", tag, j), ifm_q[j].addr, 12'(j));
        check($sformatf("%s wr%0d data", tag, j), ifm_q[j].data, base + j);
        check($sformatf("%s wr%0d ena", tag, j), ifm_q[j].en, 1'b1);
        check($sformatf("%s wr%0d cyc", tag, j), ifm_q[j].cyc, acc_cyc[j]);
      end
      check({tag, " done cnt"}, ifm_done_q.size(), 1);
      check({tag, " other done"}, flt_done_q.size(), 0);
      if (ifm_done_q.size() > 0)
        check({tag, " done cyc"}, ifm_done_q[0], (v.n == 0) ? e + 2 : last_acc + 1);
    end else begin
      check({tag, " fb count"}, fb_q.size(), v.n / 3);
      check({tag, " ifm count"}, ifm_q.size(), 0);
      for (int j = 0; j < fb_q.size() && j < v.n / 3; j++) begin
        b0 = base + 3 * j; b1 = base + 3 * j + 1; b2 = base + 3 * j + 2;
        check($sformatf("%s e%0d we", tag, j), fb_q[j].we, 4'b0001 << (j / v.c));
        check($sformatf("%s e%0d en", tag, j), fb_q[j].en, 4'b0001 << (j / v.c));
        check($sformatf("%s e%0d addr", tag, j), fb_q[j].addr, 8'(j % v.c));
        check($sformatf("%s e%0d data", tag, j), fb_q[j].data, {b2[7:0], b1, b0});
        check($sformatf("%s e%0d cyc", tag, j), fb_q[j].cyc, acc_cyc[3 * j + 2]);
      end
      check({tag, " done cnt"}, flt_done_q.size(), 1);
      check({tag, " other done"}, ifm_done_q.size(), 0);
      if (flt_done_q.size() > 0)
        check({tag, " done cyc"}, flt_done_q[0], (v.n == 0) ? e + 2 : last_acc + 1);
    end
    check({tag, " idle after"}, o_busy, 1'b0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int e;
    vecs[0] = '{1'b0, 2, 2, 3, 1'b0, 12};
    vecs[1] = '{1'b0, 2, 2, 3, 1'b1, 12};
    vecs[2] = '{1'b0, 1, 1, 1, 1'b0, 1};
    vecs[3] = '{1'b0, 3, 1, 2, 1'b1, 6};
    vecs[4] = '{1'b0, 0, 2, 3, 1'b0, 0};
    vecs[5] = '{1'b1, 0, 0, 2, 1'b0, 24};
    vecs[6] = '{1'b1, 0, 0, 1, 1'b1, 12};
    vecs[7] = '{1'b1, 0, 0, 0, 1'b0, 0};

    rst = 1'b1; q_width = '0; q_height = '0; q_channel = '0;
    q_load_ifm = 1'b0; q_load_filter = 1'b0; s_data = '0; s_valid = 1'b0;
    step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_case($sformatf("vec%0d", i), vecs[i]);

    // Both requests in one cycle: IFM first, filter follows from the pending flag.
    clear_logs();
    start_load(1'b1, 1'b1, 2, 2, 1, e);
    run_stream(16, 1'b0, 32'd0, 3);
    step(); step();
    check("both accepted", acc_n, 16);
    check("both ifm done cnt", ifm_done_q.size(), 1);
    check("both flt done cnt", flt_done_q.size(), 1);
    if (ifm_done_q.size() == 1 && flt_done_q.size() == 1) begin
      check("both order", ifm_done_q[0] < flt_done_q[0], 1'b1);
      check("both flt done cyc", flt_done_q[0], last_acc + 1);
    end
    check("both ifm wr count", ifm_q.size(), 4);
    check("both fb wr count", fb_q.size(), 4);
    if (ifm_q.size() == 4) check("both ifm last data", ifm_q[3].data, 32'd3);
    if (fb_q.size() == 4) begin
      check("both fb e0 data", fb_q[0].data, {8'h06, 32'd5, 32'd4});
      check("both fb e3 data", fb_q[3].data, {8'h0F, 32'd14, 32'd13});
      check("both fb e3 we", fb_q[3].we, 4'b1000);
    end

    // Reset after 5 of 12 beats aborts with no done, then a fresh load restarts at 0.
    clear_logs();
    start_load(1'b1, 1'b0, 2, 2, 3, e);
    run_stream(5, 1'b0, 32'h100, 0);
    rst = 1'b1;
    s_valid = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    s_valid = 1'b0;
    step(); step(); step(); step();
    check("midrst no done", ifm_done_q.size(), 0);
    check("midrst wr count", ifm_q.size(), 5);
    check("midrst idle", o_busy, 1'b0);
    run_case("restart", vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
